load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-issue RV32I load/store unit: decodes size/alignment, drives a word-wide
// synchronous data memory with byte enables and returns extended load data.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  lsu_req_vld,
  output logic                  lsu_req_rdy,
  input  logic                  lsu_req_we,
  input  logic [31:0]           lsu_req_addr,
  input  logic [31:0]           lsu_req_wdata,
  input  logic [2:0]            lsu_req_funct3,
  output logic                  lsu_rsp_vld,
  output logic [31:0]           lsu_rsp_rdata,
  output logic                  lsu_rsp_err,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wen,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rvld
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e     state;
  logic [1:0] off;
  logic [2:0] funct3;
  logic       is_store;

  // Address bits above the memory word range are deliberately dropped (wrap).
  logic unused_addr;
  assign unused_addr = ^lsu_req_addr;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [31:0] s;
    logic [31:0] r;
    s = d >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'b0, s[7:0]};
      3'b101:  r = {16'b0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= StIdle;
      off           <= 2'b00;
      funct3        <= 3'b000;
      is_store      <= 1'b0;
      lsu_req_rdy   <= 1'b0;
      lsu_rsp_vld   <= 1'b0;
      lsu_rsp_rdata <= '0;
      lsu_rsp_err   <= 1'b0;
      mem_en        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wen       <= 4'b0000;
    end else begin
      // Pulsed outputs default low; only the transitions below raise them.
      mem_en        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wen       <= 4'b0000;
      lsu_rsp_vld   <= 1'b0;
      lsu_rsp_rdata <= '0;
      lsu_rsp_err   <= 1'b0;
      unique case (state)
        StIdle: begin
          lsu_req_rdy <= 1'b1;
          if (lsu_req_vld && lsu_req_rdy) begin
            lsu_req_rdy <= 1'b0;
            off         <= lsu_req_addr[1:0];
            funct3      <= lsu_req_funct3;
            is_store    <= lsu_req_we;
            if (is_illegal(lsu_req_we, lsu_req_funct3, lsu_req_addr[1:0])) begin
              state       <= StResp;
              lsu_rsp_vld <= 1'b1;
              lsu_rsp_err <= 1'b1;
            end else begin
              state    <= StIssue;
              mem_en   <= 1'b1;
              mem_addr <= lsu_req_addr[ADDR_WIDTH+1:2];
              if (lsu_req_we) begin
                mem_wdata <= store_data(lsu_req_funct3[1:0], lsu_req_wdata);
                mem_wen   <= store_mask(lsu_req_funct3[1:0], lsu_req_addr[1:0]);
              end
            end
          end
        end
        StIssue: begin
          if (is_store) begin
            state       <= StResp;
            lsu_rsp_vld <= 1'b1;
          end else begin
            state <= StWait;
          end
        end
        StWait: begin
          if (mem_rvld) begin
            state         <= StResp;
            lsu_rsp_vld   <= 1'b1;
            lsu_rsp_rdata <= load_ext(mem_rdata, off, funct3);
          end
        end
        StResp: begin
          state       <= StIdle;
          lsu_req_rdy <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a
// response scoreboard holding expected data, error flag and latency.
module tb_load_store_unit;

  localparam int unsigned AW = 10;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b1;
  logic          lsu_req_vld = 1'b0;
  logic          lsu_req_rdy;
  logic          lsu_req_we = 1'b0;
  logic [31:0]   lsu_req_addr = '0;
  logic [31:0]   lsu_req_wdata = '0;
  logic [2:0]    lsu_req_funct3 = '0;
  logic          lsu_rsp_vld;
  logic [31:0]   lsu_rsp_rdata;
  logic          lsu_rsp_err;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wen;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rvld = 1'b0;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .lsu_req_vld    (lsu_req_vld),
    .lsu_req_rdy    (lsu_req_rdy),
    .lsu_req_we     (lsu_req_we),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_funct3 (lsu_req_funct3),
    .lsu_rsp_vld    (lsu_rsp_vld),
    .lsu_rsp_rdata  (lsu_rsp_rdata),
    .lsu_rsp_err    (lsu_rsp_err),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wen        (mem_wen),
    .mem_rdata      (mem_rdata),
    .mem_rvld       (mem_rvld)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  int          rsp_cnt = 0;
  int          rd_delay = 0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_wdata;
  logic [3:0]    last_wen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory: read data returns 1 + rd_delay cycles after the strobe.
  logic [31:0] mem [1 << AW];
  int          pend_cnt = 0;
  logic [31:0] pend_data;
  always @(posedge CLK) begin
    mem_rvld <= 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        mem_rvld  <= 1'b1;
        mem_rdata <= pend_data;
      end
    end
    if (mem_en) begin
      if (mem_wen == 4'b0000) begin
        if (rd_delay == 0) begin
          mem_rvld  <= 1'b1;
          mem_rdata <= mem[mem_addr];
        end else begin
          pend_data <= mem[mem_addr];
          pend_cnt  <= rd_delay;
        end
      end else begin
        for (int i = 0; i < 4; i++)
          if (mem_wen[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always @(negedge CLK) begin
    if (RSTN) begin
      if (mem_en) begin
        en_cnt++;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        last_wen   = mem_wen;
      end else begin
        check("mem_quiet", mem_wdata | {28'b0, mem_wen}, 32'h0);
      end
      if (lsu_rsp_vld) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_rdata", lsu_rsp_rdata, e.rdata);
          check("rsp_err", {31'b0, lsu_rsp_err}, {31'b0, e.err});
          check("rsp_latency", cyc - e.acc + 1, e.lat);
        end
      end else begin
        check("rsp_quiet", lsu_rsp_rdata | {31'b0, lsu_rsp_err}, 32'h0);
      end
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.lat   = lat;
    e.acc   = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge CLK);
      #1;
      w++;
    end
    if (sb.size() != 0) begin
      check("rsp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    int w;
    @(negedge CLK);
    lsu_req_vld    = 1'b1;
    lsu_req_we     = we;
    lsu_req_addr   = addr;
    lsu_req_wdata  = wdata;
    lsu_req_funct3 = f3;
    w = 0;
    while (!lsu_req_rdy && w < 20) begin
      @(negedge CLK);
      w++;
    end
    if (!lsu_req_rdy) begin
      check("rdy_timeout", 32'd0, 32'd1);
      lsu_req_vld = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    push_exp(exp_rdata, exp_err, exp_lat);
    lsu_req_vld = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_before;
    int rsp_before;
    int low;
    logic [31:0] b2b_addr [3];
    logic [2:0]  b2b_f3 [3];
    logic [31:0] b2b_exp [3];

    #2 RSTN = 1'b0;
    #3;
    check("reset_outputs",
          {24'b0, lsu_req_rdy, lsu_rsp_vld, lsu_rsp_err, mem_en, mem_wen} |
          lsu_rsp_rdata | mem_wdata | {22'b0, mem_addr}, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    #1 check("rdy_before_edge", {31'b0, lsu_req_rdy}, 32'd0);
    @(posedge CLK);
    #1 check("rdy_after_release", {31'b0, lsu_req_rdy}, 32'd1);

    // Stores and sub-word loads around word 4.
    access(1'b1, 32'h10, 32'h8899AABB, 3'b010, 32'h0, 1'b0, 2);
    check("sw_wen", {28'b0, last_wen}, 32'hF);
    check("sw_addr", {22'b0, last_addr}, 32'd4);
    access(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF88, 1'b0, 3);
    check("lb_addr", {22'b0, last_addr}, 32'd4);
    check("lb_wen", {28'b0, last_wen}, 32'h0);
    access(1'b0, 32'h12, 32'h0, 3'b101, 32'h00008899, 1'b0, 3);
    access(1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFAABB, 1'b0, 3);
    access(1'b1, 32'h11, 32'hCC, 3'b000, 32'h0, 1'b0, 2);
    check("sb_wdata", last_wdata, 32'hCCCCCCCC);
    check("sb_wen", {28'b0, last_wen}, 32'h2);
    access(1'b0, 32'h10, 32'h0, 3'b010, 32'h8899CCBB, 1'b0, 3);
    access(1'b1, 32'h16, 32'hABCD1234, 3'b001, 32'h0, 1'b0, 2);
    check("sh_wdata", last_wdata, 32'h12341234);
    check("sh_wen", {28'b0, last_wen}, 32'hC);
    check("sh_addr", {22'b0, last_addr}, 32'd5);
    access(1'b0, 32'h17, 32'h0, 3'b100, 32'h00000012, 1'b0, 3);
    access(1'b0, 32'h16, 32'h0, 3'b000, 32'h00000034, 1'b0, 3);
    access(1'b0, 32'h16, 32'h0, 3'b001, 32'h00001234, 1'b0, 3);
    access(1'b0, 32'h1010, 32'h0, 3'b010, 32'h8899CCBB, 1'b0, 3);
    check("wrap_addr", {22'b0, last_addr}, 32'd4);

    // Illegal accesses never reach memory.
    en_before = en_cnt;
    access(1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1, 1);
    access(1'b1, 32'h01, 32'h55, 3'b001, 32'h0, 1'b1, 1);
    access(1'b1, 32'h10, 32'h55, 3'b100, 32'h0, 1'b1, 1);
    access(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1);
    check("err_no_mem_en", 32'(en_cnt - en_before), 32'd0);

    // Reset while waiting for read data; the late mem_rvld must be dropped.
    access(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 2);
    rd_delay = 3;
    @(negedge CLK);
    lsu_req_vld    = 1'b1;
    lsu_req_we     = 1'b0;
    lsu_req_addr   = 32'h20;
    lsu_req_funct3 = 3'b010;
    @(posedge CLK);
    #1 lsu_req_vld = 1'b0;
    @(posedge CLK);
    #2;
    rsp_before = rsp_cnt;
    RSTN = 1'b0;
    #1 check("mid_reset_outputs",
             {29'b0, lsu_req_rdy, lsu_rsp_vld, mem_en} | lsu_rsp_rdata, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (6) @(negedge CLK);
    check("no_rsp_after_reset", 32'(rsp_cnt - rsp_before), 32'd0);
    check("rdy_after_mid_reset", {31'b0, lsu_req_rdy}, 32'd1);
    rd_delay = 0;
    access(1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 3);
    rd_delay = 2;
    access(1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFFCAFE, 1'b0, 5);
    rd_delay = 0;

    // Back-to-back loads with the request held valid.
    b2b_addr = '{32'h10, 32'h13, 32'h12};
    b2b_f3   = '{3'b010, 3'b000, 3'b101};
    b2b_exp  = '{32'h8899CCBB, 32'hFFFFFF88, 32'h00008899};
    @(negedge CLK);
    lsu_req_vld    = 1'b1;
    lsu_req_we     = 1'b0;
    lsu_req_addr   = b2b_addr[0];
    lsu_req_funct3 = b2b_f3[0];
    for (int k = 0; k < 3; k++) begin
      if (!lsu_req_rdy) check("b2b_rdy", 32'd0, 32'd1);
      @(posedge CLK);
      #1;
      push_exp(b2b_exp[k], 1'b0, 3);
      if (k < 2) begin
        lsu_req_addr   = b2b_addr[k+1];
        lsu_req_funct3 = b2b_f3[k+1];
        low = 0;
        @(negedge CLK);
        while (!lsu_req_rdy && low < 10) begin
          low++;
          @(negedge CLK);
        end
        check("b2b_rdy_low", 32'(low), 32'd3);
      end else begin
        lsu_req_vld = 1'b0;
      end
    end
    drain();
    repeat (3) @(negedge CLK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
